operand_phase_selector: RTL and testbench
=========================================

# operand_phase_selector

Parametrised, registered successor to the per-phase register selector in the CPU datapath. The block accepts one packed set of per-phase select codes with a `start` pulse. It then steps through `PHASES` execution phases on its own phase counter, replacing the separate phase-clock inputs, and drives the chosen source register onto a registered operand bus once per phase. It sits between the register file/stack read ports and the ALU/address operand inputs.

## Interface
- `WIDTH`, 32, data width of each source and of the output.
- `NUM_SRC`, 8, number of source registers on `src_bus`.
- `SEL_W`, 4, width of one select code; must satisfy 2^SEL_W > NUM_SRC.
- `PHASES`, 3, number of phases per sequence (≥1).
- `clock`  in  1  single block clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; accepted only while `busy`=0.
- `sel_in`  in  PHASES*SEL_W  packed select codes; phase p uses bits [p*SEL_W +: SEL_W].
- `src_bus`  in  NUM_SRC*WIDTH  packed sources; index i at [i*WIDTH +: WIDTH] (eip, ebp, esp, eax, edi, ebx, stack, stack_addr_access in the default build).
- `stall`  in  1  freeze the phase counter for this cycle.
- `out_data`  out  WIDTH  registered selected operand.
- `out_valid`  out  1  `out_data` was updated at the last edge.
- `out_phase`  out  max(1,$clog2(PHASES))  phase index that produced `out_data`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse, coincident with the last phase's output.
- `sel_err`  out  1  sticky invalid-select flag (see Configuration).

## Operation
- States: IDLE, RUN.
- IDLE, with `start`=1: latch `sel_in` into `sel_q`, set `phase`=0, enter RUN, and clear `sel_err`.
- RUN, with `stall`=0, evaluates `code`=`sel_q[phase]`:
  - `code`=0: "no output" phase. `out_valid`<=0 and `out_data` holds.
  - 1 ≤ `code` ≤ NUM_SRC: `out_data`<=src[`code`-1], `out_valid`<=1, `out_phase`<=`phase`.
  - `code`>NUM_SRC: `out_data`<=0 and `out_valid`<=1 (the operand slot is still consumed). The error flag behaviour is set under Configuration.
- After evaluation: if `phase`=PHASES-1, then `done`<=1 and the block returns to IDLE; otherwise `phase`<=`phase`+1.
- RUN, with `stall`=1: `phase`, `out_data` and `out_phase` hold, and `out_valid`<=0.
- Sources are sampled live at each evaluation edge, not at `start`.
- `start` while `busy`=1 is ignored, and `sel_q` is unchanged.
- `sel_in` is ignored except at an accepted `start`.

## Timing
- Reset (asynchronous, effective immediately): the block goes to IDLE. `phase`, `sel_q`, `out_data`, `out_valid`, `out_phase`, `busy`, `done` and `sel_err` are all 0.
- `start` is sampled at edge k. `busy`=1 from edge k.
- With no stalls, phase p is evaluated at edge k+1+p, so the first operand has latency 1 cycle.
- The last phase is evaluated at edge k+PHASES. At that edge `done`=1 and `busy`=0.
- Each stalled cycle adds exactly one cycle of latency.
- `done` lasts exactly one cycle.
- A new `start` is accepted in the cycle where `done`=1 (`busy`=0). This gives back-to-back sequences with no gap cycle.
- Reset mid-sequence: the sequence is aborted with no `done`, and all outputs return to their reset values.
- PHASES=1: `start` at edge k gives the result and `done` together at edge k+1.

## Configuration
- Macro: `OPSEL_RANGE_CHECK_EN`.
- Defined: a `code`>NUM_SRC sets `sel_err`<=1. The flag is sticky until reset or the next accepted `start`.
- Undefined: `sel_err` is tied to 0 and no check logic is built. The data path still outputs 0 for out-of-range codes.

## Test plan
- Reset, then `start` with `sel_in`={3'd phase2=2, phase1=6, phase0=3} and src[i]=32'h1000_0000+i. Required: `out_data`=32'h1000_0002, then 32'h1000_0005, then 32'h1000_0001 on three consecutive cycles, `out_phase`=0,1,2, and `done` with the third.
- Phase-0 code 0. Required: no `out_valid` in the first RUN cycle and `out_data` unchanged. Phases 1 and 2 behave normally.
- `stall` held for 2 cycles after phase 0. Required: `out_valid`=0 for 2 cycles, `out_phase` held at 0, and `done` 2 cycles later than the unstalled case.
- `start` while `busy`, with a different `sel_in`. Required: it is ignored and the outputs match the first sequence. A `start` in the `done` cycle launches the next sequence immediately.
- Code 4'hF with NUM_SRC=8. With the macro: `out_data`=0, `out_valid`=1, `sel_err`=1 until the next `start`. Without the macro: `sel_err` stays 0.
- Assert `reset` asynchronously in the middle of phase 1. Required: all outputs are 0 immediately and no `done`. A `start` after release runs a full sequence.

Source files
------------

// File: rtl/operand_phase_selector.sv
// operand_phase_selector
// Registered per-phase operand selector. A start pulse latches one packed set
// of per-phase select codes. The block then walks PHASES execution phases on
// its own counter and drives one selected source register per phase onto a
// registered operand bus.
// Optional feature macro: OPSEL_RANGE_CHECK_EN. When it is defined, a code
// above NUM_SRC raises the sticky sel_err flag. When it is undefined, no check
// logic is built and sel_err is tied low.
`timescale 1ns/1ps
module operand_phase_selector #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 4,
    parameter int PHASES  = 3,
    localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PHASES*SEL_W-1:0]    sel_in,
    input  logic [NUM_SRC*WIDTH-1:0]   src_bus,
    input  logic                       stall,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [PH_W-1:0]            out_phase,
    output logic                       busy,
    output logic                       done,
    output logic                       sel_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state_r;
    logic [PHASES*SEL_W-1:0]   sel_q_r;
    logic [PH_W-1:0]           phase_r;
    logic [WIDTH-1:0]          out_data_r;
    logic                      out_valid_r;
    logic [PH_W-1:0]           out_phase_r;
    logic                      busy_r;
    logic                      done_r;

    logic [SEL_W-1:0]          code_s;
    logic [WIDTH-1:0]          src_sel_s;
    logic                      code_zero_s;
    logic                      last_phase_s;

    // Decode the current phase's select code and mux the addressed source.
    // Codes above NUM_SRC match no source, so the mux leaves zero on the bus.
    always_comb begin
        code_s    = {SEL_W{1'b0}};
        src_sel_s = {WIDTH{1'b0}};
        for (int p = 0; p < PHASES; p++) begin
            code_s = (phase_r == PH_W'(p)) ? sel_q_r[p*SEL_W +: SEL_W] : code_s;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            src_sel_s = (code_s == SEL_W'(i + 1)) ? src_bus[i*WIDTH +: WIDTH] : src_sel_s;
        end
        code_zero_s  = (code_s == {SEL_W{1'b0}});
        last_phase_s = (phase_r == PH_W'(PHASES - 1));
    end

`ifdef OPSEL_RANGE_CHECK_EN
    logic sel_err_r;
    logic out_of_range_s;

    // Flag codes that address a source beyond the populated range.
    always_comb begin
        out_of_range_s = (code_s > SEL_W'(NUM_SRC));
    end

    // Sticky error flag. It is cleared by reset or by an accepted start, and
    // set by any evaluated out-of-range code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            sel_err_r <= 1'b0;
        end else if ((state_r == ST_RUN) && !stall && out_of_range_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign sel_err = sel_err_r;
`else
    assign sel_err = 1'b0;
`endif

    // Sequencer FSM. It accepts a start while idle, then walks the phases and
    // registers the selected operand once per unstalled cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sel_q_r     <= {(PHASES*SEL_W){1'b0}};
            phase_r     <= {PH_W{1'b0}};
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_phase_r <= {PH_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    if (start) begin
                        sel_q_r <= sel_in;
                        phase_r <= {PH_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stall) begin
                        // Freeze the phase and operand. Only the valid strobe drops.
                        out_valid_r <= 1'b0;
                        done_r      <= 1'b0;
                    end else begin
                        if (code_zero_s) begin
                            out_valid_r <= 1'b0;
                        end else begin
                            // An out-of-range code still consumes the slot, with zero data.
                            out_data_r  <= src_sel_s;
                            out_valid_r <= 1'b1;
                            out_phase_r <= phase_r;
                        end
                        if (last_phase_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            phase_r <= {PH_W{1'b0}};
                            state_r <= ST_IDLE;
                        end else begin
                            done_r  <= 1'b0;
                            phase_r <= phase_r + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    phase_r     <= {PH_W{1'b0}};
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_phase = out_phase_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_operand_phase_selector.sv
// Directed testbench for operand_phase_selector (default parameters).
// Each scenario task drives the inputs and checks a per-cycle observation
// vector {sel_err, busy, done, out_valid, out_phase, out_data} against
// hand-computed expectations.
`timescale 1ns/1ps
module tb_operand_phase_selector;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 8;
    localparam int SEL_W   = 4;
    localparam int PHASES  = 3;

`ifdef OPSEL_RANGE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic                     stall = 1'b0;
    logic [PHASES*SEL_W-1:0]  sel_in = '0;
    logic [NUM_SRC*WIDTH-1:0] src_bus;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic [1:0]               out_phase;
    logic                     busy;
    logic                     done;
    logic                     sel_err;

    int checks   = 0;
    int failures = 0;

    wire [37:0] obs = {sel_err, busy, done, out_valid, out_phase, out_data};

    operand_phase_selector #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .PHASES(PHASES)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .sel_in(sel_in),
        .src_bus(src_bus), .stall(stall), .out_data(out_data),
        .out_valid(out_valid), .out_phase(out_phase), .busy(busy),
        .done(done), .sel_err(sel_err)
    );

    always #5 clock = ~clock;

    function automatic logic [37:0] ex(input logic e, input logic b, input logic d,
                                       input logic v, input logic [1:0] ph,
                                       input logic [31:0] data);
        return {e, b, d, v, ph, data};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        if (obs !== 38'd0) begin failures++; $display("FAIL reset_async: got %h want %h", obs, 38'd0); end
        checks++;
        tick();
        if (obs !== 38'd0) begin failures++; $display("FAIL reset_held: got %h want %h", obs, 38'd0); end
        checks++;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [37:0] exp_v [5];
        exp_v[0] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        exp_v[1] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002);
        exp_v[2] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0005);
        exp_v[3] = ex(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0001);
        exp_v[4] = ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        sel_in = 12'h263;
        start  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            start = 1'b0;
            if (obs !== exp_v[c]) begin failures++; $display("FAIL basic c%0d: got %h want %h", c, obs, exp_v[c]); end
            checks++;
        end
    endtask

    task automatic test_code_zero;
        logic [37:0] exp_v [5];
        exp_v[0] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        exp_v[1] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        exp_v[2] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0000);
        exp_v[3] = ex(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0007);
        exp_v[4] = ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0007);
        sel_in = 12'h810;
        start  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            start = 1'b0;
            if (obs !== exp_v[c]) begin failures++; $display("FAIL code_zero c%0d: got %h want %h", c, obs, exp_v[c]); end
            checks++;
        end
    endtask

    task automatic test_stall;
        logic [37:0] exp_v [7];
        logic [6:0]  stall_v;
        stall_v  = 7'b0001100;
        exp_v[0] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0007);
        exp_v[1] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002);
        exp_v[2] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h1000_0002);
        exp_v[3] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h1000_0002);
        exp_v[4] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0005);
        exp_v[5] = ex(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0001);
        exp_v[6] = ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        sel_in = 12'h263;
        start  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            stall = stall_v[c];
            tick();
            start = 1'b0;
            if (obs !== exp_v[c]) begin failures++; $display("FAIL stall c%0d: got %h want %h", c, obs, exp_v[c]); end
            checks++;
        end
        stall = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [37:0] exp_v [9];
        logic [11:0] sel_v [9];
        logic [8:0]  start_v;
        start_v  = 9'b000011111;
        sel_v[0] = 12'h263;
        for (int c = 1; c < 4; c++) sel_v[c] = 12'h111;
        for (int c = 4; c < 9; c++) sel_v[c] = 12'h754;
        exp_v[0] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        exp_v[1] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002);
        exp_v[2] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0005);
        exp_v[3] = ex(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0001);
        exp_v[4] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        exp_v[5] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0003);
        exp_v[6] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0004);
        exp_v[7] = ex(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0006);
        exp_v[8] = ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0006);
        for (int c = 0; c < 9; c++) begin
            start  = start_v[c];
            sel_in = sel_v[c];
            tick();
            if (obs !== exp_v[c]) begin failures++; $display("FAIL back_to_back c%0d: got %h want %h", c, obs, exp_v[c]); end
            checks++;
        end
        start = 1'b0;
    endtask

    task automatic test_range;
        logic [37:0] exp_v [9];
        logic [8:0]  start_v;
        start_v  = 9'b000100001;
        exp_v[0] = ex(1'b0,    1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0006);
        exp_v[1] = ex(1'b0,    1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002);
        exp_v[2] = ex(EXP_ERR, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0);
        exp_v[3] = ex(EXP_ERR, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0000);
        exp_v[4] = ex(EXP_ERR, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0000);
        exp_v[5] = ex(1'b0,    1'b1, 1'b0, 1'b0, 2'd2, 32'h1000_0000);
        exp_v[6] = ex(1'b0,    1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0000);
        exp_v[7] = ex(1'b0,    1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0000);
        exp_v[8] = ex(1'b0,    1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0000);
        for (int c = 0; c < 9; c++) begin
            start  = start_v[c];
            sel_in = (c < 5) ? 12'h1F3 : 12'h111;
            tick();
            if (obs !== exp_v[c]) begin failures++; $display("FAIL range c%0d: got %h want %h", c, obs, exp_v[c]); end
            checks++;
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        logic [37:0] exp_v [5];
        sel_in = 12'h263;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        if (obs !== ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002)) begin
            failures++; $display("FAIL reset_mid_pre: got %h want %h", obs, ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002));
        end
        checks++;
        #3;
        reset = 1'b1;
        #1;
        if (obs !== 38'd0) begin failures++; $display("FAIL reset_mid_async: got %h want %h", obs, 38'd0); end
        checks++;
        tick();
        if (obs !== 38'd0) begin failures++; $display("FAIL reset_mid_nodone: got %h want %h", obs, 38'd0); end
        checks++;
        reset = 1'b0;
        tick();
        exp_v[0] = ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        exp_v[1] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h1000_0002);
        exp_v[2] = ex(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h1000_0005);
        exp_v[3] = ex(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1000_0001);
        exp_v[4] = ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0001);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            start = 1'b0;
            if (obs !== exp_v[c]) begin failures++; $display("FAIL reset_mid_rerun c%0d: got %h want %h", c, obs, exp_v[c]); end
            checks++;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_bus[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
        end
        test_reset();
        test_basic();
        test_code_zero();
        test_stall();
        test_back_to_back();
        test_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
